// File: rtl/screen_sequencer_if.sv
// Screen sequencer bus: raw pushbuttons in, registered screen status out.
interface screen_sequencer_if;
   logic       btnC;
   logic       btnU;
   logic       btnD;
   logic [3:0] state;
   logic       tick;
   logic       menu_sel;
   logic       load_done;

   modport master (
      output btnC, btnU, btnD,
      input  state, tick, menu_sel, load_done
   );

   modport slave (
      input  btnC, btnU, btnD,
      output state, tick, menu_sel, load_done
   );
endinterface

// File: rtl/screen_sequencer.sv
// Top-level screen FSM: welcome, menu, help, loading animation, game, pause.
module screen_sequencer #(
   parameter int TICK_DIV   = 10_000_000,
   parameter int LOAD_TICKS = 30
) (
   input logic                clk,
   input logic                reset,
   screen_sequencer_if.slave  bus
);
   localparam logic [3:0] WELCOME = 4'b0000;
   localparam logic [3:0] MENU    = 4'b0001;
   localparam logic [3:0] HELP    = 4'b0010;
   localparam logic [3:0] LOADING = 4'b0110;
   localparam logic [3:0] GAME    = 4'b0111;
   localparam logic [3:0] PAUSE   = 4'b1000;

   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int LW = (LOAD_TICKS > 1) ? $clog2(LOAD_TICKS) : 1;
   localparam logic [DW-1:0] DIV_MAX  = DW'(TICK_DIV - 1);
   localparam logic [LW-1:0] LOAD_MAX = LW'(LOAD_TICKS - 1);

   logic [2:0]    raw, s1, s2, prev, armed, ev;
   logic [1:0]    fill;
   logic          c, u, d;
   logic [3:0]    st, st_n;
   logic          sel, sel_n;
   logic          ld, ld_n;
   logic          tick_q, tick_n;
   logic [DW-1:0] div, div_n;
   logic [LW-1:0] lcnt, lcnt_n;
   logic          entering, done;

   assign raw = {bus.btnD, bus.btnU, bus.btnC};

   // armed only after a real released sample, so a held-through-reset
   // button yields no event until it is released and pressed again
   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= '0;
         s2    <= '0;
         prev  <= '0;
         armed <= '0;
         fill  <= '0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         prev  <= s2;
         fill  <= {fill[0], 1'b1};
         armed <= armed | ({3{fill[1]}} & ~s2);
      end
   end

   assign ev = s2 & ~prev & armed;
   assign c  = ev[0];
   assign u  = ev[1];
   assign d  = ev[2];

   assign done = (st == LOADING) && tick_q && (lcnt == LOAD_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         st     <= WELCOME;
         sel    <= 1'b0;
         ld     <= 1'b0;
         tick_q <= 1'b0;
         div    <= '0;
         lcnt   <= '0;
      end else begin
         st     <= st_n;
         sel    <= sel_n;
         ld     <= ld_n;
         tick_q <= tick_n;
         div    <= div_n;
         lcnt   <= lcnt_n;
      end
   end

   always_comb begin
      st_n = st;
      unique case (st)
         WELCOME: if (c) st_n = MENU;
         MENU:    if (c) st_n = sel ? HELP : LOADING;
         HELP:    if (c) st_n = MENU;
         LOADING: if (done) st_n = GAME;
         GAME:    if (c) st_n = PAUSE;
         PAUSE: begin
            if (c)      st_n = GAME;
            else if (u) st_n = MENU;
         end
         default: st_n = WELCOME;
      endcase
   end

   always_comb begin
      entering = (st_n == LOADING) && (st != LOADING);
      sel_n    = sel;
      if (st == MENU && !c) begin
         if (u && !d)      sel_n = 1'b0;
         else if (d && !u) sel_n = 1'b1;
      end
      ld_n   = done;
      tick_n = !entering && (div == DIV_MAX);
      if (entering || div == DIV_MAX) div_n = '0;
      else                            div_n = div + 1'b1;
      lcnt_n = '0;
      if (st == LOADING && st_n == LOADING) begin
         lcnt_n = tick_q ? lcnt + 1'b1 : lcnt;
      end
   end

   assign bus.state     = st;
   assign bus.tick      = tick_q;
   assign bus.menu_sel  = sel;
   assign bus.load_done = ld;
endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with a queued expectation scoreboard.
module tb_screen_sequencer;
   localparam int F_ST  = 0;
   localparam int F_SEL = 1;
   localparam int F_TK  = 2;
   localparam int F_LD  = 3;
   localparam int F_SEEN = 4;

   typedef struct {
      string      tag;
      int         f;
      logic [3:0] v;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic ld_seen;
   exp_t sbq[$];

   screen_sequencer_if bus ();

   screen_sequencer #(
      .TICK_DIV   (4),
      .LOAD_TICKS (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sb(input string tag, input int f, input logic [3:0] v);
      exp_t e;
      e.tag = tag;
      e.f   = f;
      e.v   = v;
      sbq.push_back(e);
   endtask

   task automatic drain();
      exp_t       e;
      logic [3:0] obs;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         case (e.f)
            F_ST:    obs = bus.state;
            F_SEL:   obs = {3'b000, bus.menu_sel};
            F_TK:    obs = {3'b000, bus.tick};
            F_LD:    obs = {3'b000, bus.load_done};
            default: obs = {3'b000, ld_seen};
         endcase
         checks++;
         assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
         end
      end
   endtask

   task automatic press(input logic bc, input logic bu, input logic bd);
      bus.btnC = bc;
      bus.btnU = bu;
      bus.btnD = bd;
      step(1);
      bus.btnC = 1'b0;
      bus.btnU = 1'b0;
      bus.btnD = 1'b0;
      step(1);
   endtask

   initial begin
      reset    = 1'b1;
      ld_seen  = 1'b0;
      bus.btnC = 1'b0;
      bus.btnU = 1'b0;
      bus.btnD = 1'b0;
      step(2);
      sb("rst_state", F_ST, 4'h0);
      sb("rst_sel", F_SEL, 4'h0);
      sb("rst_tick", F_TK, 4'h0);
      sb("rst_ld", F_LD, 4'h0);
      drain();
      reset = 1'b0;
      step(3);

      bus.btnC = 1'b1;
      step(2);
      sb("hold_pre", F_ST, 4'h0);
      drain();
      step(1);
      sb("hold_menu", F_ST, 4'h1);
      drain();
      step(17);
      bus.btnC = 1'b0;
      step(3);
      sb("hold_once", F_ST, 4'h1);
      drain();

      press(0, 0, 1); step(1);
      sb("down_sel", F_SEL, 4'h1);
      drain();
      press(1, 0, 0); step(1);
      sb("help_st", F_ST, 4'h2);
      sb("help_sel", F_SEL, 4'h1);
      drain();
      press(0, 1, 0); step(1);
      sb("help_u_st", F_ST, 4'h2);
      sb("help_u_sel", F_SEL, 4'h1);
      drain();
      press(1, 0, 0); step(1);
      sb("back_st", F_ST, 4'h1);
      sb("back_sel", F_SEL, 4'h1);
      drain();
      press(0, 1, 1); step(1);
      sb("ud_same", F_SEL, 4'h1);
      drain();
      press(0, 1, 0); step(1);
      sb("up_sel", F_SEL, 4'h0);
      drain();

      press(1, 0, 1); step(1);
      sb("ld_entry", F_ST, 4'h6);
      sb("ld_entry_sel", F_SEL, 4'h0);
      sb("ld_c0_tick", F_TK, 4'h0);
      drain();
      step(3);
      sb("ld_c3_tick", F_TK, 4'h0);
      drain();
      step(1);
      sb("ld_c4_tick", F_TK, 4'h1);
      sb("ld_c4_st", F_ST, 4'h6);
      drain();
      step(1);
      sb("ld_c5_tick", F_TK, 4'h0);
      drain();
      press(1, 1, 0);
      sb("ld_c7_st", F_ST, 4'h6);
      drain();
      step(1);
      sb("ld_c8_tick", F_TK, 4'h1);
      sb("ld_c8_st", F_ST, 4'h6);
      sb("ld_c8_ld", F_LD, 4'h0);
      drain();
      step(4);
      sb("ld_c12_tick", F_TK, 4'h1);
      sb("ld_c12_st", F_ST, 4'h6);
      sb("ld_c12_ld", F_LD, 4'h0);
      drain();
      step(1);
      sb("ld_c13_st", F_ST, 4'h7);
      sb("ld_c13_ld", F_LD, 4'h1);
      sb("ld_c13_tick", F_TK, 4'h0);
      drain();
      step(1);
      sb("ld_c14_ld", F_LD, 4'h0);
      sb("ld_c14_st", F_ST, 4'h7);
      drain();

      press(1, 0, 0); step(1);
      sb("pause", F_ST, 4'h8);
      drain();
      press(1, 1, 0); step(1);
      sb("cu_resume", F_ST, 4'h7);
      drain();
      press(1, 0, 0); step(1);
      sb("pause2", F_ST, 4'h8);
      drain();
      press(0, 1, 0); step(1);
      sb("to_menu", F_ST, 4'h1);
      sb("to_menu_sel", F_SEL, 4'h0);
      drain();

      press(1, 0, 0); step(1);
      sb("ld2_entry", F_ST, 4'h6);
      drain();
      step(5);
      reset = 1'b1;
      step(1);
      sb("midrst_st", F_ST, 4'h0);
      sb("midrst_tick", F_TK, 4'h0);
      sb("midrst_ld", F_LD, 4'h0);
      drain();
      step(1);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         ld_seen = ld_seen | bus.load_done;
      end
      sb("no_ld_pulse", F_SEEN, 4'h0);
      drain();

      press(1, 0, 0); step(1);
      sb("ld3_menu", F_ST, 4'h1);
      drain();
      press(1, 0, 0); step(1);
      sb("ld3_entry", F_ST, 4'h6);
      drain();
      step(11);
      sb("ld3_c11_tick", F_TK, 4'h0);
      drain();
      step(1);
      sb("ld3_c12_tick", F_TK, 4'h1);
      sb("ld3_c12_st", F_ST, 4'h6);
      drain();
      step(1);
      sb("ld3_c13_st", F_ST, 4'h7);
      sb("ld3_c13_ld", F_LD, 4'h1);
      drain();

      bus.btnC = 1'b1;
      reset    = 1'b1;
      step(2);
      reset = 1'b0;
      step(6);
      sb("held_rst", F_ST, 4'h0);
      drain();
      bus.btnC = 1'b0;
      step(3);
      sb("held_rel", F_ST, 4'h0);
      drain();
      press(1, 0, 0); step(1);
      sb("repress", F_ST, 4'h1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
